// File: rtl/aexm_regf_pkg.sv
// Shared encodings, FSM states and load/store sizer functions for the AEXM register file.
// Sizers work on a 64-bit view; callers zero-extend inputs and truncate results to DW.
package aexm_regf_pkg;

    typedef enum logic [1:0] {
        MXDST_RESULT = 2'd0,
        MXDST_PCLNK  = 2'd1,
        MXDST_LOAD   = 2'd2,
        MXDST_NONE   = 2'd3
    } mxdst_e;

    typedef enum logic [1:0] {
        OPC_BYTE  = 2'd0,
        OPC_HALF  = 2'd1,
        OPC_WORD  = 2'd2,
        OPC_DWORD = 2'd3
    } opc_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } regf_state_e;

    function automatic logic [7:0] lane_mask(input int unsigned w, input int unsigned o);
        return 8'(((32'd1 << w) - 32'd1) << o);
    endfunction

    // Legal selects: one aligned group of 1, 2 or 4 lanes, or every lane.
    function automatic logic load_sel_ok(input logic [7:0] sel, input int unsigned lanes);
        logic        ok;
        int unsigned w;
        ok = (sel == lane_mask(lanes, 0));
        for (int unsigned k = 0; k < 3; k++) begin
            w = 32'd1 << k;
            for (int unsigned o = 0; o < 8; o++) begin
                if (w < lanes && (o % w) == 0 && (o + w) <= lanes && sel == lane_mask(w, o))
                    ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic logic [63:0] load_size(input logic [63:0] din, input logic [7:0] sel,
                                              input logic sgn, input int unsigned lanes);
        logic [63:0] res;
        logic [63:0] sh;
        logic [63:0] m;
        int unsigned w;
        res = '0;
        sh  = '0;
        m   = '0;
        if (sel == lane_mask(lanes, 0))
            res = din;
        for (int unsigned k = 0; k < 3; k++) begin
            w = 32'd1 << k;
            for (int unsigned o = 0; o < 8; o++) begin
                if (w < lanes && (o % w) == 0 && (o + w) <= lanes && sel == lane_mask(w, o)) begin
                    sh  = din >> (8 * o);
                    m   = (64'd1 << (8 * w)) - 64'd1;
                    res = sh & m;
                    if (sgn && sh[8 * w - 1])
                        res = res | ~m;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [63:0] store_size(input logic [63:0] x, input logic [1:0] opc,
                                               input int unsigned dw);
        logic [63:0] res;
        case (opc)
            OPC_BYTE: res = {8{x[7:0]}};
            OPC_HALF: res = {4{x[15:0]}};
            OPC_WORD: res = {2{x[31:0]}};
            default:  res = (dw == 64) ? x : '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/aexm_regf_bank.sv
// One read port of the register file: 1R1W synchronous RAM with read enable,
// R0 reading as zero and same-edge write-to-read bypass.
module aexm_regf_bank
    import aexm_regf_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [NREG];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (rd_addr == '0)
                rd_data_d = '0;
            else if (wr_en && wr_addr == rd_addr)
                rd_data_d = wr_data;
            else
                rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_q <= '0;
        else
            rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/aexm_regf_gen.sv
// AEXM register file: clear sequencer, three read ports (A, B, store source D),
// writeback mux, load sizer and store sizer toward the MCU.
module aexm_regf_gen
    import aexm_regf_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            gclk,
    input  logic            grst_n,
    input  logic            d_en,
    input  logic            x_en,
    input  logic [AW-1:0]   rRW,
    input  logic [AW-1:0]   rRD,
    input  logic [AW-1:0]   regf_rRA,
    input  logic [AW-1:0]   regf_rRB,
    input  logic [AW-1:0]   regf_rRD,
    input  logic [1:0]      rMXDST,
    input  logic [DW-3:0]   rPCLNK,
    input  logic [DW-1:0]   rRESULT,
    input  logic [DW/8-1:0] rDWBSEL,
    input  logic            rSIGNED,
    input  logic [1:0]      rOPC,
    input  logic [DW-1:0]   aexm_dcache_datai,
    output logic [DW-1:0]   aexm_dcache_datao,
    output logic [DW-1:0]   xREGA,
    output logic [DW-1:0]   xREGB,
    output logic [DW-1:0]   c_io_rg,
    output logic            rf_busy,
    output logic            load_err
);

    regf_state_e   state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          rf_busy_q, rf_busy_d;
    logic          w_en_q, w_en_d;
    logic          load_err_q, load_err_d;
    logic [DW-1:0] rdwbdi_q, rdwbdi_d;

    logic [DW-1:0] xwdat;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] rregd;
    logic [DW-1:0] xdst;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rf_busy_d = (state_q == ST_CLEAR);
        w_en_d    = x_en && (state_q == ST_RUN);
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(NREG - 1))
                    state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (rMXDST)
            MXDST_RESULT: xwdat = rRESULT;
            MXDST_PCLNK:  xwdat = {rPCLNK, 2'b00};
            MXDST_LOAD:   xwdat = rdwbdi_q;
            default:      xwdat = '0;
        endcase
        // The clear sequencer owns the write port until every register is zeroed.
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt_q;
            wr_data = '0;
        end else begin
            wr_en   = w_en_q && (rRW != '0) && (rMXDST != MXDST_NONE);
            wr_addr = rRW;
            wr_data = xwdat;
        end
        rd_en = d_en && (state_q == ST_RUN);
    end

    always_comb begin
        rdwbdi_d   = DW'(load_size(64'(aexm_dcache_datai), 8'(rDWBSEL), rSIGNED, DW / 8));
        load_err_d = !load_sel_ok(8'(rDWBSEL), DW / 8);
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            rf_busy_q  <= 1'b1;
            w_en_q     <= 1'b0;
            load_err_q <= 1'b0;
            rdwbdi_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rf_busy_q  <= rf_busy_d;
            w_en_q     <= w_en_d;
            load_err_q <= load_err_d;
            rdwbdi_q   <= rdwbdi_d;
        end
    end

    aexm_regf_bank #(.DW(DW), .NREG(NREG), .AW(AW)) u_bank_a (
        .clk(gclk), .rst_n(grst_n), .rd_en(rd_en), .rd_addr(regf_rRA), .rd_data(xREGA),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    aexm_regf_bank #(.DW(DW), .NREG(NREG), .AW(AW)) u_bank_b (
        .clk(gclk), .rst_n(grst_n), .rd_en(rd_en), .rd_addr(regf_rRB), .rd_data(xREGB),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    aexm_regf_bank #(.DW(DW), .NREG(NREG), .AW(AW)) u_bank_d (
        .clk(gclk), .rst_n(grst_n), .rd_en(rd_en), .rd_addr(regf_rRD), .rd_data(rregd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always_comb begin
        if (rRW == rRD && rMXDST == MXDST_LOAD && rRW != '0)
            xdst = rdwbdi_q;
        else if (rRW == rRD && rMXDST == MXDST_RESULT && rRW != '0)
            xdst = rRESULT;
        else
            xdst = rregd;
    end

    assign aexm_dcache_datao = DW'(store_size(64'(xdst), rOPC, DW));
    assign c_io_rg  = (rRW == regf_rRA || rRW == regf_rRB) ? rRESULT : rdwbdi_q;
    assign rf_busy  = rf_busy_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_aexm_regf_gen.sv
// Scoreboard bench for aexm_regf_gen: a DW=32/NREG=32 instance for the register
// file behaviour and a DW=64/NREG=8 instance for the wide sizer paths.
module tb_aexm_regf_gen;

    localparam int unsigned NREG = 32;

    localparam int unsigned S_REGA  = 0;
    localparam int unsigned S_REGB  = 1;
    localparam int unsigned S_CIO   = 2;
    localparam int unsigned S_DATAO = 3;
    localparam int unsigned S_LERR  = 4;
    localparam int unsigned S_BUSY  = 5;
    localparam int unsigned S_DATAO64 = 6;
    localparam int unsigned S_CIO64   = 7;
    localparam int unsigned S_LERR64  = 8;

    typedef struct {
        string       tag;
        int unsigned sig;
        logic [63:0] exp;
    } sb_t;

    sb_t sb[$];
    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        d_en, x_en, sgn;
    logic [4:0]  rw, st_rd, ra, rb, rdp;
    logic [1:0]  mxdst, opc;
    logic [29:0] pclnk;
    logic [31:0] result, datai, datao, rega, regb, cio;
    logic [3:0]  sel;
    logic        busy, lerr;

    logic [63:0] r64_result, r64_datai, d64_datao, d64_rega, d64_regb, d64_cio;
    logic [7:0]  r64_sel;
    logic        r64_sgn, d64_busy, d64_lerr;
    logic [1:0]  r64_opc;

    aexm_regf_gen #(.DW(32), .NREG(NREG), .AW(5)) dut (
        .gclk(clk), .grst_n(rst_n), .d_en(d_en), .x_en(x_en),
        .rRW(rw), .rRD(st_rd), .regf_rRA(ra), .regf_rRB(rb), .regf_rRD(rdp),
        .rMXDST(mxdst), .rPCLNK(pclnk), .rRESULT(result), .rDWBSEL(sel),
        .rSIGNED(sgn), .rOPC(opc), .aexm_dcache_datai(datai),
        .aexm_dcache_datao(datao), .xREGA(rega), .xREGB(regb), .c_io_rg(cio),
        .rf_busy(busy), .load_err(lerr)
    );

    aexm_regf_gen #(.DW(64), .NREG(8), .AW(3)) dut64 (
        .gclk(clk), .grst_n(rst_n), .d_en(1'b0), .x_en(1'b0),
        .rRW(3'd1), .rRD(3'd1), .regf_rRA(3'd2), .regf_rRB(3'd2), .regf_rRD(3'd0),
        .rMXDST(2'd0), .rPCLNK(62'd0), .rRESULT(r64_result), .rDWBSEL(r64_sel),
        .rSIGNED(r64_sgn), .rOPC(r64_opc), .aexm_dcache_datai(r64_datai),
        .aexm_dcache_datao(d64_datao), .xREGA(d64_rega), .xREGB(d64_regb),
        .c_io_rg(d64_cio), .rf_busy(d64_busy), .load_err(d64_lerr)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int unsigned s);
        case (s)
            S_REGA:    return 64'(rega);
            S_REGB:    return 64'(regb);
            S_CIO:     return 64'(cio);
            S_DATAO:   return 64'(datao);
            S_LERR:    return 64'(lerr);
            S_BUSY:    return 64'(busy);
            S_DATAO64: return d64_datao;
            S_CIO64:   return d64_cio;
            default:   return 64'(d64_lerr);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int unsigned s, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic step_and_check();
        tick();
        drain();
    endtask

    // w_en is x_en delayed one edge, so the write lands on the second edge.
    task automatic wr(input logic [4:0] addr, input logic [1:0] mx, input logic [31:0] res);
        rw = addr;
        mxdst = mx;
        result = res;
        x_en = 1'b1;
        tick();
        x_en = 1'b0;
        tick();
        mxdst = 2'd3;
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic        sgn;
        logic [31:0] exp;
        logic        err;
    } ld_t;

    typedef struct {
        logic [7:0]  sel;
        logic        sgn;
        logic [63:0] exp;
        logic        err;
    } ld64_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cycles;
        ld_t   lt[$];
        ld64_t lt64[$];

        d_en = 1'b1; x_en = 1'b0; rw = '0; st_rd = 5'd7; ra = '0; rb = '0; rdp = 5'd7;
        mxdst = 2'd3; pclnk = '0; result = '0; sel = 4'hF; sgn = 1'b0; opc = 2'd2; datai = '0;
        r64_result = '0; r64_datai = '0; r64_sel = 8'hFF; r64_sgn = 1'b0; r64_opc = 2'd3;

        #12;
        check("rst_rega", 64'(rega), 64'd0);
        check("rst_regb", 64'(regb), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_lerr", 64'(lerr), 64'd0);
        check("rst_cio", 64'(cio), 64'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write requests aimed at R5 during the clear sequence must be lost.
        rw = 5'd5; mxdst = 2'd0; result = 32'h0000FFFF; ra = 5'd5; rb = 5'd0;
        cycles = 0;
        while (busy === 1'b1 && cycles < NREG + 10) begin
            x_en = (cycles < NREG - 1);
            tick();
            cycles++;
        end
        check("busy_edges", 64'(cycles), 64'(NREG + 1));
        x_en = 1'b0; mxdst = 2'd3; ra = 5'd5; rb = 5'd31;
        expect_val("clr_r5", S_REGA, 64'd0);
        expect_val("clr_r31", S_REGB, 64'd0);
        expect_val("clr_busy", S_BUSY, 64'd0);
        step_and_check();

        x_en = 1'b1; rw = 5'd5; mxdst = 2'd0; result = 32'hDEADBEEF; ra = 5'd5; rb = 5'd6;
        expect_val("byp_pre", S_REGA, 64'd0);
        step_and_check();
        x_en = 1'b0;
        expect_val("byp_a", S_REGA, 64'hDEADBEEF);
        expect_val("byp_b6", S_REGB, 64'd0);
        step_and_check();
        mxdst = 2'd3; ra = 5'd6; rb = 5'd5;
        expect_val("rd_r6", S_REGA, 64'd0);
        expect_val("rd_r5", S_REGB, 64'hDEADBEEF);
        step_and_check();

        ra = 5'd0;
        wr(5'd0, 2'd0, 32'h12345678);
        rb = 5'd0;
        expect_val("r0_a", S_REGA, 64'd0);
        expect_val("r0_b", S_REGB, 64'd0);
        step_and_check();

        wr(5'd7, 2'd0, 32'hCAFEF00D);
        pclnk = 30'h1234567;
        wr(5'd9, 2'd1, 32'h0);
        datai = 32'h11223344; sel = 4'hF;
        tick();
        wr(5'd10, 2'd2, 32'h0);
        ra = 5'd7; rb = 5'd9;
        expect_val("rd_r7", S_REGA, 64'hCAFEF00D);
        expect_val("rd_r9_pclnk", S_REGB, 64'h048D159C);
        step_and_check();
        ra = 5'd10; rb = 5'd5;
        expect_val("rd_r10_load", S_REGA, 64'h11223344);
        expect_val("rd_r5_again", S_REGB, 64'hDEADBEEF);
        step_and_check();
        d_en = 1'b0; ra = 5'd7; rb = 5'd9;
        expect_val("hold_a", S_REGA, 64'h11223344);
        expect_val("hold_b", S_REGB, 64'hDEADBEEF);
        step_and_check();
        d_en = 1'b1;

        rw = 5'd1; ra = 5'd2; rb = 5'd3; datai = 32'h80FF7F01;
        lt = '{
            '{4'h8, 1'b1, 32'hFFFFFF80, 1'b0}, '{4'h3, 1'b0, 32'h00007F01, 1'b0},
            '{4'h6, 1'b0, 32'h00000000, 1'b1}, '{4'hF, 1'b1, 32'h80FF7F01, 1'b0},
            '{4'h2, 1'b1, 32'h0000007F, 1'b0}, '{4'hC, 1'b1, 32'hFFFF80FF, 1'b0},
            '{4'h0, 1'b0, 32'h00000000, 1'b1}, '{4'h4, 1'b1, 32'hFFFFFFFF, 1'b0},
            '{4'h1, 1'b1, 32'h00000001, 1'b0}, '{4'h5, 1'b0, 32'h00000000, 1'b1},
            '{4'hC, 1'b0, 32'h000080FF, 1'b0}
        };
        foreach (lt[i]) begin
            sel = lt[i].sel;
            sgn = lt[i].sgn;
            expect_val($sformatf("load_%0d", i), S_CIO, 64'(lt[i].exp));
            expect_val($sformatf("load_err_%0d", i), S_LERR, 64'(lt[i].err));
            step_and_check();
        end

        rw = 5'd2; result = 32'h55AA55AA;
        expect_val("fwd_ra", S_CIO, 64'h55AA55AA);
        step_and_check();
        rw = 5'd3; result = 32'h00000001;
        expect_val("fwd_rb", S_CIO, 64'h00000001);
        step_and_check();

        sel = 4'hF; sgn = 1'b0;
        rw = 5'd7; st_rd = 5'd7; mxdst = 2'd0; result = 32'h000000AB; opc = 2'd0;
        expect_val("st_byte_fwd", S_DATAO, 64'hABABABAB);
        step_and_check();
        opc = 2'd1;
        expect_val("st_half_fwd", S_DATAO, 64'h00AB00AB);
        step_and_check();
        mxdst = 2'd3; opc = 2'd2;
        expect_val("st_word_reg", S_DATAO, 64'hCAFEF00D);
        step_and_check();
        opc = 2'd1;
        expect_val("st_half_reg", S_DATAO, 64'hF00DF00D);
        step_and_check();
        opc = 2'd0;
        expect_val("st_byte_reg", S_DATAO, 64'h0D0D0D0D);
        step_and_check();
        opc = 2'd3;
        expect_val("st_dword_dw32", S_DATAO, 64'h0);
        step_and_check();
        mxdst = 2'd2; opc = 2'd2;
        expect_val("st_load_fwd", S_DATAO, 64'h80FF7F01);
        step_and_check();
        mxdst = 2'd0; st_rd = 5'd8;
        expect_val("st_addr_mismatch", S_DATAO, 64'hCAFEF00D);
        step_and_check();

        r64_result = 64'h0123456789ABCDEF;
        r64_opc = 2'd3;
        expect_val("st64_dword", S_DATAO64, 64'h0123456789ABCDEF);
        step_and_check();
        r64_opc = 2'd2;
        expect_val("st64_word", S_DATAO64, 64'h89ABCDEF89ABCDEF);
        step_and_check();
        r64_opc = 2'd0;
        expect_val("st64_byte", S_DATAO64, 64'hEFEFEFEFEFEFEFEF);
        step_and_check();

        r64_datai = 64'h89ABCDEF00008001;
        lt64 = '{
            '{8'hF0, 1'b1, 64'hFFFFFFFF89ABCDEF, 1'b0}, '{8'hC0, 1'b0, 64'h00000000000089AB, 1'b0},
            '{8'h30, 1'b1, 64'hFFFFFFFFFFFFCDEF, 1'b0}, '{8'hFF, 1'b1, 64'h89ABCDEF00008001, 1'b0},
            '{8'h18, 1'b0, 64'h0000000000000000, 1'b1}, '{8'h03, 1'b1, 64'hFFFFFFFFFFFF8001, 1'b0},
            '{8'h0F, 1'b1, 64'h0000000000008001, 1'b0}, '{8'h0F, 1'b0, 64'h0000000000008001, 1'b0},
            '{8'hF8, 1'b0, 64'h0000000000000000, 1'b1}
        };
        foreach (lt64[i]) begin
            r64_sel = lt64[i].sel;
            r64_sgn = lt64[i].sgn;
            expect_val($sformatf("load64_%0d", i), S_CIO64, lt64[i].exp);
            expect_val($sformatf("load64_err_%0d", i), S_LERR64, 64'(lt64[i].err));
            step_and_check();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
